// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM encodings, bus mode and default word width
// used by both the master and the responder.
package spi_pkg;
  localparam int SPI_CPOL   = 0;
  localparam int SPI_CPHA   = 0;
  localparam int SPI_WORD_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input, followed by
// single-cycle rise/fall pulse detection on the synchronised level.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;
  logic                   lvl;

  assign lvl = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev   <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev   <= lvl;
    end
  end

  assign rise = lvl & ~prev;
  assign fall = ~lvl & prev;
endmodule

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 responder, MSB first: oversamples the bus in clk, shifts
// N-bit words in on mosi and out on miso from a one-deep holding register.
module spi_slave_shifter
  import spi_pkg::*;
#(
  parameter int N           = SPI_WORD_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sclk,
  input  logic         cs_n,
  input  logic         mosi,
  output logic         miso,
  output logic         miso_oe,
  input  logic [N-1:0] tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  output logic [N-1:0] rx_data,
  output logic         rx_valid,
  output logic         busy,
  output logic         tx_underrun
);
  localparam int CNT_W = $clog2(N);

  spi_state_e             state, state_nxt;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   mosi_s;
  logic [CNT_W-1:0]       bit_cnt;
  logic [N-1:0]           rx_sreg, tx_sreg, hold_data;
  logic                   hold_full;
  logic                   word_load, do_shift, do_sample, go_idle;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .din(cs_n), .rise(cs_rise), .fall(cs_fall)
  );

  // mosi is only sampled on sclk edges, so it needs no edge detector
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mosi_q <= '0;
    else      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    word_load = 1'b0;
    do_shift  = 1'b0;
    do_sample = 1'b0;
    go_idle   = 1'b0;
    miso_oe   = 1'b0;
    miso      = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs_fall) begin
          state_nxt = ST_SHIFT;
          word_load = 1'b1;
        end
      end
      ST_SHIFT: begin
        miso_oe = 1'b1;
        miso    = tx_sreg[N-1];
        busy    = 1'b1;
        // deselect outranks any sclk edge seen in the same cycle
        if (cs_rise) begin
          state_nxt = ST_IDLE;
          go_idle   = 1'b1;
        end else begin
          do_sample = sclk_rise;
          if (sclk_fall) begin
            if (bit_cnt == '0) word_load = 1'b1;
            else               do_shift  = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt     <= '0;
      rx_sreg     <= '0;
      tx_sreg     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      if (go_idle) begin
        bit_cnt <= '0;
        rx_sreg <= '0;
        tx_sreg <= '0;
      end
      if (do_sample) begin
        rx_sreg <= {rx_sreg[N-2:0], mosi_s};
        if (bit_cnt == CNT_W'(N-1)) begin
          bit_cnt  <= '0;
          rx_data  <= {rx_sreg[N-2:0], mosi_s};
          rx_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (word_load) begin
        if (hold_full) begin
          tx_sreg <= hold_data;
        end else begin
          tx_sreg     <= '0;
          tx_underrun <= 1'b1;
        end
      end else if (do_shift) begin
        tx_sreg <= {tx_sreg[N-2:0], 1'b0};
      end
    end
  end

  // A load only happens while empty, so it never collides with consumption;
  // a load racing an underrun word load simply waits for the next word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (word_load && hold_full) begin
      hold_full <= 1'b0;
    end else if (tx_valid && !hold_full) begin
      hold_full <= 1'b1;
      hold_data <= tx_data;
    end
  end

  assign tx_ready = ~hold_full;
endmodule

// File: tb/tb_spi_slave_shifter.sv
// Directed bench for spi_slave_shifter: a behavioural mode-0 master with
// sclk = clk/8 and hand-computed expected words.
module tb_spi_slave_shifter;
  logic       clk = 1'b0;
  logic       rst, sclk, cs_n, mosi;
  logic       miso, miso_oe, tx_valid, tx_ready, rx_valid, busy, tx_underrun;
  logic [7:0] tx_data, rx_data, got;
  int         checks = 0;
  int         errors = 0;
  int         rx_cnt = 0;
  int         un_cnt = 0;
  int         r0, u0;

  spi_slave_shifter #(.N(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid === 1'b1)    rx_cnt++;
    if (tx_underrun === 1'b1) un_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    gap(8);
  endtask

  // Shifts nbits of m (MSB first); with last set, cs_n rises on the same
  // instant as the final sclk fall.
  task automatic send_bits(input logic [7:0] m, input int nbits, input bit last,
                           output logic [7:0] s);
    s = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = m[i];
      gap(4);
      sclk = 1'b1;
      s[i] = miso;
      gap(4);
      sclk = 1'b0;
      if (last && i == 8 - nbits) cs_n = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = '0;
    #12;
    chk("rst_miso_oe", miso_oe, 0);
    chk("rst_miso", miso, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", tx_underrun, 0);
    @(negedge clk) rst = 1'b1;
    gap(4);

    // single word
    load(8'hD5);
    chk("single_tx_ready_full", tx_ready, 0);
    r0 = rx_cnt; u0 = un_cnt;
    cs_low();
    chk("single_tx_ready_back", tx_ready, 1);
    chk("single_busy", busy, 1);
    chk("single_miso_oe", miso_oe, 1);
    send_bits(8'h3C, 8, 1'b1, got);
    gap(8);
    chk("single_miso_word", got, 8'hD5);
    chk("single_rx_data", rx_data, 8'h3C);
    chk("single_rx_pulses", rx_cnt - r0, 1);
    chk("single_underruns", un_cnt - u0, 0);
    chk("single_idle_oe", miso_oe, 0);

    // back-to-back words, second word loaded mid-way through the first
    load(8'hA5);
    r0 = rx_cnt; u0 = un_cnt;
    cs_low();
    fork
      send_bits(8'h96, 8, 1'b0, got);
      begin gap(20); load(8'h0F); end
    join
    chk("b2b_miso_word0", got, 8'hA5);
    chk("b2b_rx_word0", rx_data, 8'h96);
    send_bits(8'h71, 8, 1'b1, got);
    gap(8);
    chk("b2b_miso_word1", got, 8'h0F);
    chk("b2b_rx_word1", rx_data, 8'h71);
    chk("b2b_rx_pulses", rx_cnt - r0, 2);
    chk("b2b_underruns", un_cnt - u0, 0);

    // underrun
    r0 = rx_cnt; u0 = un_cnt;
    cs_low();
    send_bits(8'h81, 8, 1'b1, got);
    gap(8);
    chk("under_pulses", un_cnt - u0, 1);
    chk("under_miso_word", got, 8'h00);
    chk("under_rx_data", rx_data, 8'h81);
    chk("under_rx_pulses", rx_cnt - r0, 1);

    // abort after 5 bits, then a clean word
    r0 = rx_cnt;
    cs_low();
    send_bits(8'hFF, 5, 1'b1, got);
    gap(3);
    chk("abort_miso_oe", miso_oe, 0);
    chk("abort_busy", busy, 0);
    gap(6);
    chk("abort_rx_pulses", rx_cnt - r0, 0);
    chk("abort_rx_hold", rx_data, 8'h81);
    load(8'h3C);
    r0 = rx_cnt; u0 = un_cnt;
    cs_low();
    send_bits(8'h5A, 8, 1'b1, got);
    gap(8);
    chk("post_abort_rx", rx_data, 8'h5A);
    chk("post_abort_miso", got, 8'h3C);
    chk("post_abort_pulses", rx_cnt - r0, 1);
    chk("post_abort_under", un_cnt - u0, 0);

    // asynchronous reset in the middle of a word
    load(8'h96);
    cs_low();
    send_bits(8'hE7, 3, 1'b0, got);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_miso_oe", miso_oe, 0);
    chk("mid_rst_miso", miso, 0);
    chk("mid_rst_tx_ready", tx_ready, 1);
    chk("mid_rst_rx_data", rx_data, 8'h00);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_underrun", tx_underrun, 0);
    cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    gap(2);
    rst = 1'b1;
    gap(4);
    load(8'hC3);
    r0 = rx_cnt; u0 = un_cnt;
    cs_low();
    send_bits(8'hE7, 8, 1'b1, got);
    gap(8);
    chk("post_rst_miso", got, 8'hC3);
    chk("post_rst_rx", rx_data, 8'hE7);
    chk("post_rst_pulses", rx_cnt - r0, 1);
    chk("post_rst_under", un_cnt - u0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
